// File: rtl/dlx_pkg.sv
// Shared types and constants for the DLX instruction fetch slice.
package dlx_pkg;

  localparam int          DLX_WORD_W = 32;
  localparam logic [31:0] DLX_NOP    = 32'h0000_0000;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    DRAIN = 3'd2,
    HOLD  = 3'd3,
    FAULT = 3'd4
  } ifetch_state_t;

  function automatic logic is_word_aligned(input logic [DLX_WORD_W-1:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/dlx_ifetch_timer.sv
// Saturating wait counter for the fetch request; expired pulses on the cycle
// whose closing edge would bring the count to ACK_TIMEOUT (0 = never).
module dlx_ifetch_timer #(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int          CW     = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam bit          TO_ON  = (ACK_TIMEOUT > 0);
  localparam logic [CW-1:0] C_MAX  = TO_ON ? CW'(ACK_TIMEOUT)     : '0;
  localparam logic [CW-1:0] C_LAST = TO_ON ? CW'(ACK_TIMEOUT - 1) : '0;

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (en && (r_cnt != C_MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign expired = TO_ON && en && (r_cnt == C_LAST);

endmodule

// File: rtl/dlx_ifetch.sv
// DLX instruction fetch: req/ack memory read into the IR with flush/timeout.
// Optional misaligned-address fault when DLX_IFETCH_ALIGN_CHK_EN is defined.
module dlx_ifetch
  import dlx_pkg::*;
#(
  parameter int          ACK_TIMEOUT = 255,
  parameter logic [31:0] RESET_IR    = DLX_NOP
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DLX_WORD_W-1:0] i_address,
  input  logic                  fetch_start,
  input  logic                  flush,
  output logic                  imem_req,
  output logic [DLX_WORD_W-1:0] imem_addr,
  input  logic                  imem_ack,
  input  logic [DLX_WORD_W-1:0] imem_rdata,
  output logic [DLX_WORD_W-1:0] ir,
  output logic                  ir_valid,
  input  logic                  ir_consume,
  output logic                  fetch_busy,
  output logic                  fetch_fault
);

  ifetch_state_t         r_state;
  ifetch_state_t         w_state_nxt;
  logic [DLX_WORD_W-1:0] r_addr;
  logic [DLX_WORD_W-1:0] r_ir;
  logic                  r_req;
  logic                  r_valid;
  logic                  r_fault;
  logic                  w_launch;
  logic                  w_capture;
  logic                  w_aligned;
  logic                  w_tmr_en;
  logic                  w_expired;

`ifdef DLX_IFETCH_ALIGN_CHK_EN
  assign w_aligned = is_word_aligned(i_address);
`else
  assign w_aligned = 1'b1;
`endif

  // Only unacknowledged, unflushed REQ cycles count towards the timeout.
  assign w_tmr_en = (r_state == REQ) && !imem_ack && !flush;

  dlx_ifetch_timer #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (w_launch),
    .en      (w_tmr_en),
    .expired (w_expired)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_launch    = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        if (fetch_start) begin
          w_launch = 1'b1;
        end
      end
      REQ: begin
        if (imem_ack) begin
          if (flush) begin
            w_state_nxt = IDLE;
          end else begin
            w_capture   = 1'b1;
            w_state_nxt = HOLD;
          end
        end else if (flush) begin
          w_state_nxt = DRAIN;
        end else if (w_expired) begin
          w_state_nxt = FAULT;
        end
      end
      DRAIN: begin
        if (imem_ack) begin
          w_state_nxt = IDLE;
        end
      end
      HOLD: begin
        if (flush) begin
          w_state_nxt = IDLE;
        end else if (ir_consume) begin
          if (fetch_start) begin
            w_launch = 1'b1;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      FAULT: begin
        if (flush) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (w_launch) begin
      w_state_nxt = w_aligned ? REQ : FAULT;
    end
  end

  // Outputs are flopped from the next-state decode so they stay glitch-free.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_ir    <= RESET_IR;
      r_req   <= 1'b0;
      r_valid <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_launch) begin
        r_addr <= i_address;
      end
      if (w_capture) begin
        r_ir <= imem_rdata;
      end
      r_req   <= (w_state_nxt == REQ) || (w_state_nxt == DRAIN);
      r_valid <= (w_state_nxt == HOLD);
      r_fault <= (w_state_nxt == FAULT);
    end
  end

  assign imem_req    = r_req;
  assign imem_addr   = r_addr;
  assign ir          = r_ir;
  assign ir_valid    = r_valid;
  assign fetch_busy  = r_req;
  assign fetch_fault = r_fault;

endmodule

// File: tb/tb_dlx_ifetch.sv
// Self-checking bench for dlx_ifetch: directed scenarios plus random traffic
// against a transaction-level reference model.
module tb_dlx_ifetch;

  localparam int          TO  = 4;
  localparam logic [31:0] RIR = 32'hA5A5_0001;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] i_address;
  logic        fetch_start;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] ir;
  logic        ir_valid;
  logic        ir_consume;
  logic        fetch_busy;
  logic        fetch_fault;

  dlx_ifetch #(.ACK_TIMEOUT(TO), .RESET_IR(RIR)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_address   (i_address),
    .fetch_start (fetch_start),
    .flush       (flush),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .ir          (ir),
    .ir_valid    (ir_valid),
    .ir_consume  (ir_consume),
    .fetch_busy  (fetch_busy),
    .fetch_fault (fetch_fault)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: an outstanding request (possibly being discarded),
  // a held instruction, or a reported fault.
  bit          m_req, m_drain, m_valid, m_fault;
  logic [31:0] m_addr, m_ir;
  int          m_waits;

  function automatic void model_reset();
    m_req = 0; m_drain = 0; m_valid = 0; m_fault = 0;
    m_addr = 32'h0; m_ir = RIR; m_waits = 0;
  endfunction

  function automatic void model_launch();
    m_addr  = i_address;
    m_waits = 0;
`ifdef DLX_IFETCH_ALIGN_CHK_EN
    if (i_address[1:0] != 2'b00) m_fault = 1;
    else m_req = 1;
`else
    m_req = 1;
`endif
  endfunction

  function automatic void model_edge();
    if (m_fault) begin
      if (flush) m_fault = 0;
    end else if (m_req && !m_drain) begin
      if (imem_ack) begin
        m_req = 0;
        if (!flush) begin
          m_ir = imem_rdata;
          m_valid = 1;
        end
      end else if (flush) begin
        m_drain = 1;
      end else begin
        m_waits++;
        if (TO != 0 && m_waits == TO) begin
          m_req = 0;
          m_fault = 1;
        end
      end
    end else if (m_drain) begin
      if (imem_ack) begin
        m_req = 0;
        m_drain = 0;
      end
    end else if (m_valid) begin
      if (flush) m_valid = 0;
      else if (ir_consume) begin
        m_valid = 0;
        if (fetch_start) model_launch();
      end
    end else if (fetch_start) begin
      model_launch();
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    chk("imem_req", {31'b0, imem_req}, {31'b0, m_req});
    chk("imem_addr", imem_addr, m_addr);
    chk("ir", ir, m_ir);
    chk("ir_valid", {31'b0, ir_valid}, {31'b0, m_valid});
    chk("fetch_busy", {31'b0, fetch_busy}, {31'b0, m_req});
    chk("fetch_fault", {31'b0, fetch_fault}, {31'b0, m_fault});
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic idle_inputs();
    fetch_start = 0; flush = 0; imem_ack = 0; ir_consume = 0;
    i_address = 32'h0; imem_rdata = 32'h0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 0;
    idle_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_ir", ir, RIR);
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", {31'b0, ir_valid}, 32'h0);
    chk("rst_busy", {31'b0, fetch_busy}, 32'h0);
    chk("rst_fault", {31'b0, fetch_fault}, 32'h0);
    reset_n = 1;

    // zero-wait fetch
    i_address = 32'h100; fetch_start = 1; step(); fetch_start = 0;
    chk("zw_req", {31'b0, imem_req}, 32'h1);
    imem_ack = 1; imem_rdata = 32'h2002_0005; step(); imem_ack = 0;
    chk("zw_valid", {31'b0, ir_valid}, 32'h1);
    chk("zw_ir", ir, 32'h2002_0005);
    chk("zw_addr", imem_addr, 32'h100);
    chk("zw_req_low", {31'b0, imem_req}, 32'h0);
    ir_consume = 1; step(); ir_consume = 0;
    chk("cons_valid", {31'b0, ir_valid}, 32'h0);

    // 3-wait fetch with address changing under the request
    i_address = 32'h100; fetch_start = 1; step(); fetch_start = 0;
    i_address = 32'h200;
    repeat (3) step();
    chk("w3_req", {31'b0, imem_req}, 32'h1);
    chk("w3_addr", imem_addr, 32'h100);
    imem_ack = 1; imem_rdata = 32'h8C41_0004; step(); imem_ack = 0;
    chk("w3_req_low", {31'b0, imem_req}, 32'h0);
    chk("w3_ir", ir, 32'h8C41_0004);

    // back-to-back consume + start
    i_address = 32'h104; ir_consume = 1; fetch_start = 1; step();
    ir_consume = 0; fetch_start = 0;
    chk("b2b_valid", {31'b0, ir_valid}, 32'h0);
    chk("b2b_req", {31'b0, imem_req}, 32'h1);
    chk("b2b_addr", imem_addr, 32'h104);

    // flush during REQ, late ack discarded
    flush = 1; step(); flush = 0;
    chk("dr_busy", {31'b0, fetch_busy}, 32'h1);
    step();
    chk("dr_valid", {31'b0, ir_valid}, 32'h0);
    imem_ack = 1; imem_rdata = 32'hDEAD_BEEF; step(); imem_ack = 0;
    chk("dr_ir", ir, 32'h8C41_0004);
    chk("dr_valid2", {31'b0, ir_valid}, 32'h0);
    chk("dr_idle", {31'b0, fetch_busy}, 32'h0);

    // timeout
    i_address = 32'h300; fetch_start = 1; step(); fetch_start = 0;
    repeat (3) step();
    chk("to_nofault", {31'b0, fetch_fault}, 32'h0);
    chk("to_req_hi", {31'b0, imem_req}, 32'h1);
    step();
    chk("to_fault", {31'b0, fetch_fault}, 32'h1);
    chk("to_req_lo", {31'b0, imem_req}, 32'h0);
    flush = 1; step(); flush = 0;
    chk("to_clr", {31'b0, fetch_fault}, 32'h0);
    chk("to_idle", {31'b0, fetch_busy}, 32'h0);

`ifdef DLX_IFETCH_ALIGN_CHK_EN
    i_address = 32'h102; fetch_start = 1; step(); fetch_start = 0;
    chk("al_req", {31'b0, imem_req}, 32'h0);
    chk("al_fault", {31'b0, fetch_fault}, 32'h1);
    chk("al_addr", imem_addr, 32'h102);
    flush = 1; step(); flush = 0;
`endif

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      fetch_start = ($urandom_range(0, 99) < 40);
      ir_consume  = ($urandom_range(0, 99) < 40);
      flush       = ($urandom_range(0, 99) < 8);
      imem_ack    = m_req && ($urandom_range(0, 99) < 35);
      imem_rdata  = $urandom;
      i_address   = $urandom;
      if ($urandom_range(0, 99) < 80) i_address[1:0] = 2'b00;
      step();
    end

    // return to IDLE from any state, then reset asynchronously mid-REQ
    idle_inputs();
    flush = 1; imem_ack = m_req; step(); flush = 0; imem_ack = 0;
    i_address = 32'h400; fetch_start = 1; step(); fetch_start = 0;
    chk("ar_req_hi", {31'b0, imem_req}, 32'h1);
    #2 reset_n = 0;
    #1;
    chk("ar_req", {31'b0, imem_req}, 32'h0);
    chk("ar_addr", imem_addr, 32'h0);
    chk("ar_ir", ir, RIR);
    chk("ar_valid", {31'b0, ir_valid}, 32'h0);
    chk("ar_busy", {31'b0, fetch_busy}, 32'h0);
    chk("ar_fault", {31'b0, fetch_fault}, 32'h0);
    model_reset();
    @(negedge clk);
    reset_n = 1;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dlx_ifetch.md
# dlx_ifetch

Instruction fetch unit of the DLX core, directly downstream of the program counter. It captures the PC's instruction address on request, runs a variable-latency req/ack read on the instruction memory port, and holds the returned word in the instruction register (IR) until the decoder consumes it. It also reports bus timeouts and, optionally, misaligned fetch addresses.

## Interface
Parameters:
- ACK_TIMEOUT, 255: maximum number of REQ cycles to wait for `imem_ack`; 0 disables the timeout.
- RESET_IR, 32'h0000_0000: reset value of `ir`.

Ports:
- clk  in  1  core clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- i_address  in  32  instruction address from the PC.
- fetch_start  in  1  fetch request from the sequencer; sampled only in IDLE, or in HOLD together with `ir_consume`.
- flush  in  1  abort the current fetch and discard the IR.
- imem_req  out  1  memory read request.
- imem_addr  out  32  read address; stable while `imem_req` is high.
- imem_ack  in  1  read data valid this cycle.
- imem_rdata  in  32  read data, valid when `imem_ack` is high.
- ir  out  32  instruction register.
- ir_valid  out  1  `ir` holds an unconsumed instruction.
- ir_consume  in  1  decoder takes `ir`; ignored unless `ir_valid` is high.
- fetch_busy  out  1  high in REQ and DRAIN.
- fetch_fault  out  1  sticky fault flag; cleared by `flush` or reset.

## Operation
- States:
  - IDLE: waiting for `fetch_start`.
  - REQ: `imem_req` asserted, waiting for `imem_ack`.
  - DRAIN: a flushed request still waiting for its `imem_ack`.
  - HOLD: `ir` valid, waiting for `ir_consume`.
  - FAULT: fault reported, waiting for `flush`.
- IDLE & fetch_start: latch `imem_addr <= i_address`, clear the wait counter, go to REQ.
- REQ & imem_ack: `ir <= imem_rdata`, set `ir_valid`, go to HOLD.
- REQ & !imem_ack: the wait counter increments and saturates.
  - When it reaches ACK_TIMEOUT (ACK_TIMEOUT≠0): deassert `imem_req`, set `fetch_fault`, go to FAULT.
  - The memory must ignore an abandoned request.
- REQ & flush: go to DRAIN. `imem_req` stays high until `imem_ack`, then the data is discarded and the state returns to IDLE.
  - `flush` and `imem_ack` in the same cycle: the data is discarded, go directly to IDLE.
- HOLD & ir_consume:
  - Clear `ir_valid`.
  - If `fetch_start` is also high, latch the new address and go straight to REQ (back-to-back fetch). Otherwise go to IDLE.
- HOLD & flush: clear `ir_valid`, go to IDLE. `flush` wins over `ir_consume`.
- FAULT & flush: clear `fetch_fault`, go to IDLE.
- IDLE & flush: no effect apart from clearing `fetch_fault`.
- `ir` keeps its value when `ir_valid` drops; only `imem_ack` in REQ writes it.
- `imem_addr` is not updated outside the IDLE→REQ and HOLD→REQ transitions, even if `i_address` changes.

## Timing
- Reset (asynchronous, immediate) values: state IDLE; `imem_req` 0; `imem_addr` 0; `ir` RESET_IR; `ir_valid` 0; `fetch_busy` 0; `fetch_fault` 0.
- `fetch_start` sampled at edge N → `imem_req` high from N+1.
- `imem_ack` at edge M → `ir_valid` high from M+1, and `imem_req` low from M+1.
- Minimum latency from `fetch_start` to `ir_valid` is 2 edges, with a zero-wait ack.
- Timeout: with no ack, `fetch_fault` rises after exactly ACK_TIMEOUT cycles of `imem_req` high.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Reset asserted during REQ or DRAIN drops `imem_req` asynchronously. The memory must tolerate this.

## Configuration
- With `DLX_IFETCH_ALIGN_CHK_EN` defined:
  - On `fetch_start` with `i_address[1:0]≠0`, no request is issued.
  - `fetch_fault` is set and the state goes to FAULT on the next edge; `imem_addr` still latches the address.
- Without it: the address is passed unchanged and no alignment fault exists.

## Structure
- `dlx_pkg` holds:
  - the state enum `ifetch_state_t` (IDLE, REQ, DRAIN, HOLD, FAULT);
  - the constants `DLX_WORD_W = 32` and `DLX_NOP = 32'h0000_0000`.
- One sub-module, `dlx_ifetch_timer`: the wait counter, with `clear`/`en` inputs and a `expired` output, sized `$clog2(ACK_TIMEOUT+1)`. The FSM, IR and address register live in `dlx_ifetch`.

## Test plan
- Zero-wait fetch: `i_address` = 0x100, `fetch_start` pulse, `imem_ack` on the first REQ cycle with rdata 0x2002_0005 → `imem_addr` = 0x100, `ir` = 0x2002_0005, `ir_valid` high 2 edges after the start.
- 3-wait fetch, with `i_address` changed to 0x200 during REQ → `imem_addr` stays 0x100 and `imem_req` stays high for 4 cycles.
- HOLD with `ir_consume` and `fetch_start` both high, `i_address` = 0x104 → `ir_valid` low for one cycle, new REQ to 0x104, no IDLE cycle.
- `flush` during REQ, ack 2 cycles later with 0xDEAD_BEEF → state DRAIN, `ir_valid` never rises, `ir` is unchanged, state returns to IDLE.
- ACK_TIMEOUT = 4, no ack → `fetch_fault` high after 4 REQ cycles and `imem_req` low; `flush` → `fetch_fault` 0, state IDLE.
- With `DLX_IFETCH_ALIGN_CHK_EN`: `i_address` = 0x102, `fetch_start` → `imem_req` never asserts and `fetch_fault` is high next cycle. Also assert `reset_n` low mid-REQ → all outputs at their reset values before the next clock edge.
